pwm_regs_mc: RTL
================

# pwm_regs_mc

Parametrised multi-channel register file for the PWM generator, successor to the single-channel byte-addressed map. It serves one global counter block and NCH compare/function channels. Channel registers are double-buffered: staged shadow values transfer to the active outputs atomically at a counter period boundary. It also provides tear-free 16-bit counter readback and a sticky overflow status flag. It sits between the SPI/bus decoder and the counter and PWM channel logic.

## Interface
- NCH, 4: number of PWM channels, legal range 1..7.
- CW, 16: counter/period/compare width, legal range 9..16.
- clk  in  1  peripheral clock, all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- read  in  1  read strobe from decoder, one cycle.
- write  in  1  write strobe from decoder, one cycle.
- addr  in  6  byte address.
- data_write  in  8  write data.
- data_read  out  8  registered read data.
- counter_val  in  CW  live counter value.
- period_evt  in  1  one-cycle pulse from counter at period wrap.
- period  out  CW  counter period (global, not shadowed).
- en, upnotdown, pwm_en  out  1 each  counter enable, direction, global PWM enable.
- prescale  out  8  prescaler.
- count_reset  out  1  one-cycle counter reset pulse.
- compare1, compare2  out  CW*NCH each  active compare values; channel n occupies bits [CW*n +: CW].
- functions  out  8*NCH  active function bytes, channel n at [8*n +: 8].
- ch_en  out  NCH  active per-channel enables.

## Operation
Global map:
- 0x00/0x01 PERIOD L/H.
- 0x02 CTRL: bit0 en, bit1 upnotdown, bit2 pwm_en.
- 0x03 PRESCALE.
- 0x04 CNT_L: read only.
- 0x05 CNT_H: read only.
- 0x06 CMD: write only, reads 0; bit0 count_reset, bit1 force_update.
- 0x07 STATUS: bit0 update_pending (RO), bit1 ovf (W1C).

Per-channel map, base = 0x08 + 8*n:
- +0/+1 CMP1 L/H, +2/+3 CMP2 L/H, +4 FUNCTIONS, +5 CH_EN (bit0).
- +6/+7 reserved: read 0, writes ignored.
- Any address at or above 0x08 + 8*NCH, and any unmapped address: read 0, writes ignored.

Width rules:
- High bytes carry bits [CW-1:8]. Unused upper bits are write-ignored and read 0.

Shadowing:
- Channel writes land in shadow registers and set update_pending.
- A transfer copies every shadow register into the active outputs and clears update_pending.
- A transfer fires on period_evt, or in the cycle after a CMD write with bit1 = 1.
- Readback of channel registers returns the shadow value.

Counter snapshot:
- A read of 0x04 returns counter_val[7:0] and, in the same edge, captures counter_val[CW-1:8] into snap_hi.
- A read of 0x05 returns snap_hi, never the live value.

ovf flag:
- Set by period_evt.
- Cleared by a write to 0x07 with bit1 = 1.

## Timing
- Reset values: period 0, en 0, upnotdown 1, pwm_en 0, prescale 0, count_reset 0, all compares/functions/ch_en 0 (shadow and active), data_read 0, update_pending 0, ovf 0, snap_hi 0.
- data_read updates on the edge that samples read, so it is valid the next cycle. It holds until the next read.
- Writes take effect on the sampling edge. Global outputs change visibly the next cycle.
- count_reset is high for exactly one cycle after a CMD write with bit0 = 1. It is 0 otherwise.
- Read and write to the same address in the same cycle: data_read returns the pre-write value.
- Write to a shadow register in the same cycle as a transfer:
  - The transfer uses the pre-write shadow contents.
  - The new value stays in shadow.
  - update_pending ends at 1.
- period_evt and an ovf W1C in the same cycle: set wins, so ovf ends at 1.
- period_evt with update_pending = 0 still performs a transfer. This is harmless because shadow equals active.
- Reset asserted mid-operation: all state returns to reset values asynchronously. A pending transfer is discarded.

## Configuration
- PWMREGS_SHADOW_EN defined: double-buffering as described above.
- PWMREGS_SHADOW_EN undefined:
  - No shadow registers; channel writes update the active outputs directly on the write edge.
  - update_pending reads 0.
  - CMD bit1 is ignored.
  - period_evt only sets ovf.

## Test plan
- Reset, then read every mapped address -> all read 0 except 0x02 = 0x02 (upnotdown set).
- NCH=4, shadow on: write ch2 CMP1 = 0x1234 -> compare1[47:32] stays 0 and STATUS = 0x01; pulse period_evt -> compare1[47:32] = 0x1234 and STATUS = 0x02.
- counter_val = 0x00AB, read 0x04 -> 0xAB; counter_val changes to 0x3C00, read 0x05 -> 0x00 (snapshot, not 0x3C).
- Write 0x01 to 0x06 -> count_reset high for exactly one cycle; write 0x02 with a pending shadow value -> active outputs update the next cycle.
- ovf set by period_evt; in the same cycle as another period_evt, write 0x02 to 0x07 -> ovf remains 1; a later W1C alone -> ovf = 0.
- CW=12: write 0xFF to PERIOD_H -> period = 0xF00 and readback = 0x0F; write to 0x08 + 8*NCH -> no output change, readback 0.

Source files
------------

// File: rtl/pwm_regs_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_regs_mc_if
//  Description : Decoder-side register bus for the multi-channel PWM
//                register file. The decoder (master) issues one-cycle read
//                and write strobes with a byte address and write data.
//                The register file (slave) returns registered read data.
//  Signals     : read        1  read strobe, one cycle
//                write       1  write strobe, one cycle
//                addr        6  byte address
//                data_write  8  write data
//                data_read   8  registered read data
//  Revision    : 1.0  initial release
// ============================================================================
interface pwm_regs_mc_if;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;

  modport master (
    output read,
    output write,
    output addr,
    output data_write,
    input  data_read
  );

  modport slave (
    input  read,
    input  write,
    input  addr,
    input  data_write,
    output data_read
  );
endinterface
`default_nettype wire

// File: rtl/pwm_regs_mc.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_regs_mc
//  Description : Multi-channel register file for the PWM generator. Holds
//                the global counter controls (period, enables, prescaler,
//                command pulses, status) and NCH compare/function channels.
//                Channel writes land in a staging copy; with double
//                buffering enabled the staging copy moves to the active
//                outputs atomically on a period boundary or on a forced
//                update. Counter readback is made tear-free by capturing
//                the high bits when the low byte is read.
//  Config      : PWMREGS_SHADOW_EN - when defined, channel registers are
//                double-buffered; when undefined, channel writes drive the
//                outputs directly and update_pending always reads 0.
//  Parameters  : NCH  number of channels (1..7)
//                CW   counter/period/compare width (9..16)
//  Ports       : clk, rst_n        clock, async active-low reset
//                bus               decoder bus (slave modport)
//                counter_val_i     live counter value
//                period_evt_i      period wrap pulse
//                period_o          counter period
//                en_o, upnotdown_o, pwm_en_o  counter control bits
//                prescale_o        prescaler
//                count_reset_o     one-cycle counter reset pulse
//                compare1_o/compare2_o  active compares, ch n at [CW*n +: CW]
//                functions_o       active function bytes, ch n at [8*n +: 8]
//                ch_en_o           active per-channel enables
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_regs_mc #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_regs_mc_if.slave        bus,
  input  logic [CW-1:0]       counter_val_i,
  input  logic                period_evt_i,
  output logic [CW-1:0]       period_o,
  output logic                en_o,
  output logic                upnotdown_o,
  output logic                pwm_en_o,
  output logic [7:0]          prescale_o,
  output logic                count_reset_o,
  output logic [CW*NCH-1:0]   compare1_o,
  output logic [CW*NCH-1:0]   compare2_o,
  output logic [8*NCH-1:0]    functions_o,
  output logic [NCH-1:0]      ch_en_o
);

  localparam logic [2:0] c_NCH3 = 3'(NCH);
  localparam int         c_HW   = CW - 8;   // bits carried by a high byte

  // Zero-extend a CW-bit value to 16 bits and return its upper byte, so
  // unused high bits read back as 0 for any CW.
  function automatic logic [7:0] hi_byte(input logic [CW-1:0] v);
    logic [15:0] ext;
    ext         = '0;
    ext[CW-1:0] = v;
    return ext[15:8];
  endfunction

  // --------------------------------------------------------------------------
  // Address decode: addr[5:3] selects the block (0 = global, k = channel k-1),
  // addr[2:0] selects the register inside the block.
  // --------------------------------------------------------------------------
  logic [2:0] w_blk;
  logic [2:0] w_off;
  logic       w_glb;
  logic       w_chsel;
  logic       w_gwr;
  logic       w_ch_wr;
  logic       w_cmd_wr;
  logic [7:0] w_dw;

  assign w_blk    = bus.addr[5:3];
  assign w_off    = bus.addr[2:0];
  assign w_dw     = bus.data_write;
  assign w_glb    = (w_blk == 3'd0);
  assign w_chsel  = !w_glb && (w_blk <= c_NCH3);
  assign w_gwr    = bus.write && w_glb;
  // Offsets 6/7 of a channel are reserved and must not mark an update.
  assign w_ch_wr  = bus.write && w_chsel && (w_off < 3'd6);
  assign w_cmd_wr = w_gwr && (w_off == 3'd6);

  // --------------------------------------------------------------------------
  // Global registers
  // --------------------------------------------------------------------------
  logic [CW-1:0]   period_q;
  logic            en_q;
  logic            upnotdown_q;
  logic            pwm_en_q;
  logic [7:0]      prescale_q;
  logic            count_reset_q;
  logic [c_HW-1:0] snap_hi_q;
  logic            ovf_q;
  logic            ovf_d;
  logic [7:0]      data_read_q;
  logic [7:0]      w_rdata;
  logic            w_pend;

  // A period event in the same cycle as a W1C keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (period_evt_i) begin
      ovf_d = 1'b1;
    end else if (w_gwr && (w_off == 3'd7) && w_dw[1]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q      <= '0;
      en_q          <= 1'b0;
      upnotdown_q   <= 1'b1;
      pwm_en_q      <= 1'b0;
      prescale_q    <= 8'h00;
      count_reset_q <= 1'b0;
      snap_hi_q     <= '0;
      ovf_q         <= 1'b0;
      data_read_q   <= 8'h00;
    end else begin
      count_reset_q <= w_cmd_wr && w_dw[0];
      ovf_q         <= ovf_d;
      if (w_gwr) begin
        case (w_off)
          3'd0:    period_q[7:0]    <= w_dw;
          3'd1:    period_q[CW-1:8] <= w_dw[c_HW-1:0];
          3'd2: begin
            en_q        <= w_dw[0];
            upnotdown_q <= w_dw[1];
            pwm_en_q    <= w_dw[2];
          end
          3'd3:    prescale_q       <= w_dw;
          default: ;
        endcase
      end
      // Read data is taken from the pre-write register contents.
      if (bus.read) begin
        data_read_q <= w_rdata;
      end
      // Reading the low counter byte freezes the high part for CNT_H.
      if (bus.read && w_glb && (w_off == 3'd4)) begin
        snap_hi_q <= counter_val_i[CW-1:8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Staged channel registers: written by the bus and read back by the bus.
  // --------------------------------------------------------------------------
  logic [NCH-1:0][CW-1:0] stg_cmp1_q;
  logic [NCH-1:0][CW-1:0] stg_cmp2_q;
  logic [NCH-1:0][7:0]    stg_func_q;
  logic [NCH-1:0]         stg_chen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_cmp1_q <= '0;
      stg_cmp2_q <= '0;
      stg_func_q <= '0;
      stg_chen_q <= '0;
    end else if (w_ch_wr) begin
      for (int n = 0; n < NCH; n++) begin
        if (w_blk == 3'(n + 1)) begin
          case (w_off)
            3'd0:    stg_cmp1_q[n][7:0]    <= w_dw;
            3'd1:    stg_cmp1_q[n][CW-1:8] <= w_dw[c_HW-1:0];
            3'd2:    stg_cmp2_q[n][7:0]    <= w_dw;
            3'd3:    stg_cmp2_q[n][CW-1:8] <= w_dw[c_HW-1:0];
            3'd4:    stg_func_q[n]         <= w_dw;
            3'd5:    stg_chen_q[n]         <= w_dw[0];
            default: ;
          endcase
        end
      end
    end
  end

`ifdef PWMREGS_SHADOW_EN
  // --------------------------------------------------------------------------
  // Double buffering: the staged copy is the shadow, transferred into the
  // active copy on a period event or one cycle after a forced update command.
  // --------------------------------------------------------------------------
  logic [NCH-1:0][CW-1:0] act_cmp1_q;
  logic [NCH-1:0][CW-1:0] act_cmp2_q;
  logic [NCH-1:0][7:0]    act_func_q;
  logic [NCH-1:0]         act_chen_q;
  logic                   upd_pend_q;
  logic                   upd_pend_d;
  logic                   fupd_q;
  logic                   w_xfer;

  assign w_xfer = period_evt_i || fupd_q;

  // A channel write coinciding with a transfer leaves its value staged, so
  // the pending flag must win over the clear.
  always_comb begin
    upd_pend_d = upd_pend_q;
    if (w_ch_wr) begin
      upd_pend_d = 1'b1;
    end else if (w_xfer) begin
      upd_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_cmp1_q <= '0;
      act_cmp2_q <= '0;
      act_func_q <= '0;
      act_chen_q <= '0;
      upd_pend_q <= 1'b0;
      fupd_q     <= 1'b0;
    end else begin
      fupd_q     <= w_cmd_wr && w_dw[1];
      upd_pend_q <= upd_pend_d;
      // Copies the pre-write shadow: a same-edge bus write lands in the
      // shadow only.
      if (w_xfer) begin
        act_cmp1_q <= stg_cmp1_q;
        act_cmp2_q <= stg_cmp2_q;
        act_func_q <= stg_func_q;
        act_chen_q <= stg_chen_q;
      end
    end
  end

  assign compare1_o  = act_cmp1_q;
  assign compare2_o  = act_cmp2_q;
  assign functions_o = act_func_q;
  assign ch_en_o     = act_chen_q;
  assign w_pend      = upd_pend_q;
`else
  // Single-buffered: the staged copy drives the outputs directly.
  assign compare1_o  = stg_cmp1_q;
  assign compare2_o  = stg_cmp2_q;
  assign functions_o = stg_func_q;
  assign ch_en_o     = stg_chen_q;
  assign w_pend      = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read multiplexer (channel registers read back their staged value)
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = 8'h00;
    if (w_glb) begin
      case (w_off)
        3'd0:    w_rdata = period_q[7:0];
        3'd1:    w_rdata = hi_byte(period_q);
        3'd2:    w_rdata = {5'b0, pwm_en_q, upnotdown_q, en_q};
        3'd3:    w_rdata = prescale_q;
        3'd4:    w_rdata = counter_val_i[7:0];
        3'd5:    w_rdata = hi_byte({snap_hi_q, 8'h00});
        3'd7:    w_rdata = {6'b0, ovf_q, w_pend};
        default: w_rdata = 8'h00;
      endcase
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (w_blk == 3'(n + 1)) begin
          case (w_off)
            3'd0:    w_rdata = stg_cmp1_q[n][7:0];
            3'd1:    w_rdata = hi_byte(stg_cmp1_q[n]);
            3'd2:    w_rdata = stg_cmp2_q[n][7:0];
            3'd3:    w_rdata = hi_byte(stg_cmp2_q[n]);
            3'd4:    w_rdata = stg_func_q[n];
            3'd5:    w_rdata = {7'b0, stg_chen_q[n]};
            default: w_rdata = 8'h00;
          endcase
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.data_read = data_read_q;
  assign period_o      = period_q;
  assign en_o          = en_q;
  assign upnotdown_o   = upnotdown_q;
  assign pwm_en_o      = pwm_en_q;
  assign prescale_o    = prescale_q;
  assign count_reset_o = count_reset_q;

endmodule
`default_nettype wire
